// File: rtl/rs_pkg.sv
// Shared constants, state encoding and GF(2^8) helper for the RS(255,239) encoder sequencer.
package rs_pkg;

  localparam int K    = 239;
  localparam int NPAR = 16;
  localparam int W    = 8;
  localparam int FCW  = 16;
  localparam int CW   = $clog2(K + 1);
  localparam int PCW  = $clog2(NPAR);

  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } state_e;

  // GF(2^8) multiply, reduction by GF_POLY; shared with the multiplier bank models.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic [W-1:0] x;
    p = {W{1'b0}};
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = x[W-1] ? ({x[W-2:0], 1'b0} ^ GF_POLY[W-1:0]) : {x[W-2:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_enc_sequencer_out_stage.sv
// rs_out_stage: single registered valid/ready output slot carrying a symbol plus sop/eop sideband.
module rs_out_stage
  import rs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         sop_i,
  input  logic         eop_i,
  input  logic         out_ready_i,
  output logic         free_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         out_sop_o,
  output logic         out_eop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         sop_q, sop_d;
  logic         eop_q, eop_d;

  assign free_o = !valid_q || out_ready_i;

  // Slot next-state: load wins, otherwise a consumed slot empties; data is kept after drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sop_d   = sop_i;
      eop_d   = eop_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_sop_o   = sop_q;
  assign out_eop_o   = eop_q;

endmodule

// File: rtl/rs_enc_sequencer.sv
// RS(255,239) frame sequencer: message pass-through, LFSR feedback control, parity drain from r_15.
// Optional RS_SHORTEN_EN adds in_last_i to end the message early (shortened code).
module rs_enc_sequencer
  import rs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  input  logic [W-1:0]   in_data_i,
  input  logic           in_sop_i,
`ifdef RS_SHORTEN_EN
  input  logic           in_last_i,
`endif
  output logic           in_ready_o,
  input  logic [W-1:0]   r_15_i,
  output logic [W-1:0]   fb_sym_o,
  output logic           fb_en_o,
  output logic           sh_en_o,
  output logic           lfsr_clr_o,
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
  output logic           out_sop_o,
  output logic           out_eop_o,
  input  logic           out_ready_i,
  output logic [FCW-1:0] frames_done_o,
  output logic           err_sop_o
);

  state_e         state_q, state_d;
  logic [CW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [PCW-1:0] par_cnt_q, par_cnt_d;
  logic [FCW-1:0] frames_q, frames_d;
  logic           err_q, err_d;

  logic           free_s, in_ready_s, accept_s, take_s, drain_s, eop_s, load_s;
  logic           last_in_s, last_s;
  logic [W-1:0]   load_data_s;

`ifdef RS_SHORTEN_EN
  assign last_in_s = in_last_i;
`else
  assign last_in_s = 1'b0;
`endif

  assign last_s = (sym_cnt_q == CW'(K - 1)) || last_in_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= {CW{1'b0}};
      par_cnt_q <= {PCW{1'b0}};
      frames_q  <= {FCW{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      par_cnt_q <= par_cnt_d;
      frames_q  <= frames_d;
      err_q     <= err_d;
    end
  end

  // Next-state and counters.
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    par_cnt_d = par_cnt_q;
    frames_d  = frames_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (take_s) begin
          sym_cnt_d = CW'(1);
          par_cnt_d = {PCW{1'b0}};
          state_d   = last_in_s ? PAR : MSG;
        end else if (accept_s) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MSG: begin
        if (accept_s) begin
          sym_cnt_d = sym_cnt_q + CW'(1);
          err_d     = err_q | in_sop_i;
          if (last_s) begin
            state_d   = PAR;
            par_cnt_d = {PCW{1'b0}};
          end else begin
            state_d = MSG;
          end
        end else begin
          state_d = MSG;
        end
      end
      PAR: begin
        if (drain_s) begin
          par_cnt_d = par_cnt_q + PCW'(1);
          if (eop_s) begin
            state_d   = IDLE;
            sym_cnt_d = {CW{1'b0}};
            frames_d  = frames_q + FCW'(1);
          end else begin
            state_d = PAR;
          end
        end else begin
          state_d = PAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes and LFSR controls; a sop-less symbol in IDLE is dropped and never feeds the LFSR.
  always_comb begin
    in_ready_s  = rst && free_s && (state_q != PAR);
    accept_s    = in_valid_i && in_ready_s;
    take_s      = accept_s && ((state_q == MSG) || in_sop_i);
    drain_s     = rst && free_s && (state_q == PAR);
    eop_s       = drain_s && (par_cnt_q == PCW'(NPAR - 1));
    load_s      = take_s || drain_s;
    load_data_s = drain_s ? r_15_i : in_data_i;
    fb_en_o     = take_s;
    sh_en_o     = drain_s;
    fb_sym_o    = take_s ? (in_data_i ^ r_15_i) : {W{1'b0}};
  end

  rs_out_stage u_out (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .data_i      (load_data_s),
    .sop_i       (state_q == IDLE),
    .eop_i       (eop_s),
    .out_ready_i (out_ready_i),
    .free_o      (free_s),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_sop_o   (out_sop_o),
    .out_eop_o   (out_eop_o)
  );

  assign in_ready_o    = in_ready_s;
  assign lfsr_clr_o    = !rst;
  assign frames_done_o = frames_q;
  assign err_sop_o     = err_q;

endmodule

// File: tb/tb_rs_enc_sequencer.sv
// Bench for rs_enc_sequencer: LFSR bank model, long-division golden parity, scoreboarded output checks.
module tb_rs_enc_sequencer;
  import rs_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_sop_i;
`ifdef RS_SHORTEN_EN
  logic        in_last_i;
`endif
  logic        in_ready_o;
  logic [7:0]  r_15;
  logic [7:0]  fb_sym_o;
  logic        fb_en_o, sh_en_o, lfsr_clr_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_sop_o, out_eop_o;
  logic        out_ready_i;
  logic [15:0] frames_done_o;
  logic        err_sop_o;

  rs_enc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_sop_i      (in_sop_i),
`ifdef RS_SHORTEN_EN
    .in_last_i     (in_last_i),
`endif
    .in_ready_o    (in_ready_o),
    .r_15_i        (r_15),
    .fb_sym_o      (fb_sym_o),
    .fb_en_o       (fb_en_o),
    .sh_en_o       (sh_en_o),
    .lfsr_clr_o    (lfsr_clr_o),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_sop_o     (out_sop_o),
    .out_eop_o     (out_eop_o),
    .out_ready_i   (out_ready_i),
    .frames_done_o (frames_done_o),
    .err_sop_o     (err_sop_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  typedef struct {
    int   len;
    int   pat;
    int   stall;
    logic last;
    int   exp_outs;
  } vec_t;

  exp_t       sbq[$];
  vec_t       tbl[$];
  int         sop_cyc[$];
  logic [7:0] g [17];
  logic [7:0] lfsr [16];
  logic [7:0] gpar [16];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, stall_pct = 0;
  int out_cnt = 0, fb_cnt = 0, sh_cnt = 0, proto_err = 0, exp_frames = 0, n_last = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Remainder of m(x)*x^16 mod g(x) by long division over the full codeword array.
  function automatic void golden(input logic [7:0] msg[$]);
    logic [7:0] arr[$];
    logic [7:0] c;
    arr = msg;
    for (int i = 0; i < 16; i++) arr.push_back(8'h00);
    for (int j = 0; j < msg.size(); j++) begin
      c = arr[j];
      for (int t = 1; t <= 16; t++) arr[j+t] = arr[j+t] ^ gmul(c, g[16-t]);
    end
    for (int j = 0; j < 16; j++) gpar[j] = arr[msg.size()+j];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Parity LFSR bank around the sequencer.
  always @(posedge clk) begin
    if (lfsr_clr_o) begin
      for (int i = 0; i < 16; i++) lfsr[i] <= 8'h00;
    end else if (fb_en_o) begin
      lfsr[0] <= gmul(g[0], fb_sym_o);
      for (int i = 1; i < 16; i++) lfsr[i] <= lfsr[i-1] ^ gmul(g[i], fb_sym_o);
    end else if (sh_en_o) begin
      lfsr[0] <= 8'h00;
      for (int i = 1; i < 16; i++) lfsr[i] <= lfsr[i-1];
    end
  end
  assign r_15 = lfsr[15];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
    end
  end

  // Output monitor and LFSR-control protocol checks, sampled mid-cycle.
  initial begin
    logic       stall_prev;
    logic [7:0] hold_d;
    logic       hold_s, hold_e;
    exp_t       e;
    stall_prev = 1'b0;
    hold_d = 8'h00; hold_s = 1'b0; hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (fb_en_o) begin
        fb_cnt++;
        if (fb_sym_o !== (in_data_i ^ r_15)) proto_err++;
      end else if (fb_sym_o !== 8'h00) begin
        proto_err++;
      end
      if (sh_en_o) sh_cnt++;
      if (fb_en_o && sh_en_o) proto_err++;
      if (stall_prev)
        check("stall_hold", {out_valid_o, out_sop_o, out_eop_o, out_data_o}, {1'b1, hold_s, hold_e, hold_d});
      stall_prev = out_valid_o && !out_ready_i && rst;
      hold_d = out_data_o; hold_s = out_sop_o; hold_e = out_eop_o;
      if (out_valid_o && out_ready_i && rst) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("out_word", {out_sop_o, out_eop_o, out_data_o}, {e.sop, e.eop, e.data});
        end
      end
    end
  end

  task automatic drive_sym(input logic [7:0] d, input logic sop, input logic last);
    int   budget;
    logic acc;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_sop_i   = sop;
`ifdef RS_SHORTEN_EN
    in_last_i  = last;
`endif
    if (last) n_last++;
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 2000) begin
      @(negedge clk);
      acc = in_ready_o;
      if (acc && sop) sop_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int n, input int pat, input int sop_at, input logic use_last);
    logic [7:0] msg[$];
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       msg.push_back(8'((i + 1) % 256));
        1:       msg.push_back(8'h00);
        default: msg.push_back(8'($urandom_range(255)));
      endcase
    end
    golden(msg);
    for (int i = 0; i < n; i++) sbq.push_back('{msg[i], (i == 0), 1'b0});
    for (int j = 0; j < 16; j++) sbq.push_back('{gpar[j], 1'b0, (j == 15)});
    exp_frames++;
    for (int i = 0; i < n; i++)
      drive_sym(msg[i], (i == 0) || (i == sop_at), use_last && (i == n - 1));
    in_valid_i = 1'b0;
    in_sop_i   = 1'b0;
`ifdef RS_SHORTEN_EN
    in_last_i  = 1'b0;
`endif
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sbq.size() != 0 && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a;
    rst = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    in_sop_i   = 1'b0;
`ifdef RS_SHORTEN_EN
    in_last_i  = 1'b0;
`endif
    // Generator g(x) = prod (x + alpha^i), i = 0..15, ascending coefficients.
    g[0] = 8'h01;
    for (int i = 1; i < 17; i++) g[i] = 8'h00;
    a = 8'h01;
    for (int k = 0; k < 16; k++) begin
      for (int j = 16; j >= 1; j--) g[j] = g[j-1] ^ gmul(g[j], a);
      g[0] = gmul(g[0], a);
      a = gmul(a, 8'h02);
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_lfsr_clr", lfsr_clr_o, 32'd1);
    check("rst_out_valid", {out_valid_o, out_sop_o, out_eop_o}, 32'd0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_frames", frames_done_o, 32'd0);
    check("rst_err", err_sop_o, 32'd0);
    check("rst_in_ready", in_ready_o, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_lfsr_clr", lfsr_clr_o, 32'd0);
    check("idle_in_ready", in_ready_o, 32'd1);

    tbl.push_back('{K, 0, 0, 1'b0, K + NPAR});
    tbl.push_back('{K, 2, 50, 1'b0, K + NPAR});
    tbl.push_back('{K, 0, 50, 1'b0, K + NPAR});
`ifdef RS_SHORTEN_EN
    tbl.push_back('{100, 2, 0, 1'b1, 116});
    tbl.push_back('{1, 2, 30, 1'b1, 17});
    tbl.push_back('{K, 2, 0, 1'b1, K + NPAR});
`endif
    foreach (tbl[i]) begin
      stall_pct = tbl[i].stall;
      out_cnt = 0; fb_cnt = 0; sh_cnt = 0;
      send_frame(tbl[i].len, tbl[i].pat, -1, tbl[i].last);
      drain();
      check("vec_outs", out_cnt, tbl[i].exp_outs);
      check("vec_fb_pulses", fb_cnt, tbl[i].len);
      check("vec_sh_pulses", sh_cnt, 32'd16);
      check("vec_frames", frames_done_o, exp_frames);
      check("vec_err", err_sop_o, 32'd0);
    end

    // Back-to-back zero frames: next sop accepted right after the last parity drains.
    stall_pct = 0;
    out_cnt = 0; fb_cnt = 0; sh_cnt = 0;
    sop_cyc.delete();
    send_frame(K, 1, -1, 1'b0);
    send_frame(K, 1, -1, 1'b0);
    drain();
    check("b2b_outs", out_cnt, 32'd510);
    check("b2b_fb_pulses", fb_cnt, 32'd478);
    if (sop_cyc.size() == 2) check("b2b_sop_gap", sop_cyc[1] - sop_cyc[0], 32'd255);
    else check("b2b_sop_count", sop_cyc.size(), 32'd2);
    check("b2b_frames", frames_done_o, exp_frames);

    // Symbol without sop in IDLE is dropped and flags err_sop.
    out_cnt = 0;
    drive_sym(8'hAA, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_err", err_sop_o, 32'd1);
    check("drop_no_out", out_cnt, 32'd0);

    // sop in the middle of a message: flagged, treated as data.
    out_cnt = 0;
    send_frame(K, 2, 99, 1'b0);
    drain();
    check("midsop_outs", out_cnt, 32'd255);
    check("midsop_err", err_sop_o, 32'd1);
    check("midsop_frames", frames_done_o, exp_frames);

    // One-cycle reset at message symbol 50 discards the partial frame.
    out_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      sbq.push_back('{8'(i + 1), (i == 0), 1'b0});
      drive_sym(8'(i + 1), (i == 0), 1'b0);
    end
    in_valid_i = 1'b0;
    in_sop_i   = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_lfsr_clr", lfsr_clr_o, 32'd1);
    @(posedge clk);
    #1;
    check("mid_rst_out", {out_valid_o, out_sop_o, out_eop_o}, 32'd0);
    check("mid_rst_frames", frames_done_o, 32'd0);
    check("mid_rst_err", err_sop_o, 32'd0);
    rst = 1'b1;
    sbq.delete();
    exp_frames = 0;
    @(posedge clk);
    #1;
    out_cnt = 0;
    send_frame(K, 0, -1, 1'b0);
    drain();
    check("post_rst_outs", out_cnt, 32'd255);
    check("post_rst_frames", frames_done_o, 32'd1);

    check("fb_protocol", proto_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_enc_sequencer.md
Name: rs_enc_sequencer

Overview:
Frame sequencer and flow controller for the RS(255,239) systematic encoder datapath over GF(2^8).
- Accepts message symbols from an upstream valid/ready source.
- Drives the parity LFSR feedback symbol and its shift/feedback enables.
- Emits the 239 message symbols followed by 16 parity symbols, drained from the LFSR head (r_15), on a registered valid/ready output with sop/eop.
- Sits between the framer and the channel interleaver, around the existing GF-multiplier/LFSR bank.

Parameters:
K, 239, message symbols per codeword
NPAR, 16, parity symbols per codeword (LFSR depth)
W, 8, symbol width in bits
FCW, 16, width of the completed-frame counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  upstream symbol valid
in_data  in  W  upstream message symbol
in_sop  in  1  first symbol of a message
in_ready  out  1  sequencer can accept in_data this cycle
r_15  in  W  LFSR head register (next parity symbol)
fb_sym  out  W  LFSR feedback symbol
fb_en  out  1  LFSR: load with feedback this cycle
sh_en  out  1  LFSR: plain shift toward r_15, zero fill
lfsr_clr  out  1  LFSR synchronous clear
out_valid  out  1  output symbol valid
out_data  out  W  output symbol
out_sop  out  1  first symbol of codeword
out_eop  out  1  last parity symbol of codeword
out_ready  in  1  downstream accepts
frames_done  out  FCW  completed codewords, wraps
err_sop  out  1  sticky: sop protocol violation seen

Behaviour:
Reset:
- While rst=0, set state=IDLE, counters=0 and out_valid/out_sop/out_eop/err_sop=0.
- out_data=0 and frames_done=0.
- lfsr_clr=1 while rst=0, and 0 otherwise.
- A reset mid-frame discards the partial codeword. No eop is emitted.

Output stage:
- Single register. The slot is free when (!out_valid || out_ready).
- The output holds while out_valid && !out_ready.

States:
- IDLE:
  - in_ready = slot free.
  - Accept (in_valid && in_ready && in_sop): out_data<=in_data, out_sop<=1, sym_cnt<=1, go to MSG.
  - Accepted symbol without sop: dropped, err_sop<=1, stay IDLE.
- MSG:
  - in_ready = slot free.
  - Each accept: out_data<=in_data, sym_cnt++.
  - sop seen mid-frame: err_sop<=1; the symbol is treated as ordinary data.
  - Accept with sym_cnt==K-1: go to PAR, par_cnt<=0.
- PAR:
  - in_ready=0.
  - Each free-slot cycle: out_data<=r_15, sh_en=1, par_cnt++.
  - par_cnt==NPAR-1 drain: out_eop<=1, frames_done++, go to IDLE.

Feedback and enables:
- fb_en = accept strobe in IDLE or MSG. It is combinational, same cycle as the transfer.
- fb_sym = in_data ^ r_15 when fb_en is 1, else 0.
- fb_en and sh_en are never both high.
- After NPAR shifts the LFSR is zero, so no clear is needed between frames.

Latency and throughput:
- One cycle from input accept to out_valid.
- Full throughput of 255 symbols per 255 cycles when out_ready=1.
- Next frame's sop is accepted the cycle after the last parity drains, which gives a 16-cycle input bubble per frame.

Other boundaries:
- frames_done wraps 2^FCW-1 -> 0.
- out_sop is asserted only with the first message symbol.
- out_eop is asserted only with parity 16.

Optional Feature:
Macro RS_SHORTEN_EN:
- Enabled:
  - Adds input in_last (1 bit).
  - An accept with in_last=1 ends MSG early at any sym_cnt from 1 to K, giving a shortened RS code. Shortened symbols are implicit zeros and never transmitted.
  - Reaching K without in_last still ends the message.
  - in_last together with sop in IDLE gives a 1-symbol message.
- Disabled:
  - No in_last port. The message length is fixed at K.

Decomposition:
- Package rs_pkg holds:
  - K, NPAR, W and GF polynomial 0x11D.
  - Enumerated state type {IDLE, MSG, PAR}.
  - Counter width localparam clog2(K+1).
- One natural sub-module: rs_out_stage, the registered valid/ready output slot with sop/eop sideband.
- The FSM and counters stay in the top.

Test Plan:
- Message 1..239 with out_ready=1: 255 outputs. Input symbol 1 appears as out_data=1, out_sop=1. Parity symbols match the golden RS(255,239) model. out_eop is on output 255. frames_done=1.
- All-zero message: all 16 parity symbols =0. fb_sym=0 throughout. The second frame is accepted the cycle after eop.
- out_ready random 50% during message and parity: output identical to the stall-free run. fb_en and sh_en pulse exactly 239 and 16 times. The output never changes while stalled.
- Symbol without sop in IDLE gives a drop and err_sop=1. sop at symbol 100 gives err_sop held, and the frame continues to 255 outputs.
- rst=0 at message symbol 50 for 1 cycle: lfsr_clr=1, out_valid=0. The next full frame is correct and frames_done=0 before it.
- RS_SHORTEN_EN: 100-symbol message with in_last gives 116 outputs. Parity equals the golden model with 139 leading zeros. A 1-symbol sop+last frame gives 17 outputs.
